// File: rtl/kmeans_pkg.sv
// Shared types and widths for the K-means iteration controller and its divider.
package kmeans_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_PASS,
        S_DRAIN,
        S_DIV,
        S_CHECK,
        S_DONE
    } state_t;

    localparam int PIX_W = 24;
    localparam int CH_W  = 8;
    localparam int ACC_W = 24;
    localparam int CNT_W = 12;

    // One quotient bit per dividend bit; the load cycle comes on top of this.
    localparam int DIV_STEPS = ACC_W;

    function automatic logic [CH_W-1:0] absDiff(input logic [CH_W-1:0] a, input logic [CH_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/kmeans_seq_div.sv
// Restoring divider, 24-bit sum by 12-bit count, 8-bit saturated quotient.
// Optional KMEANS_ROUND_EN biases the dividend by half the divisor for round-to-nearest.
module kmeans_seq_div
    import kmeans_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [ACC_W-1:0]   i_dividend,
    input  logic [CNT_W-1:0]   i_divisor,
    output logic               o_busy,
    output logic               o_done,
    output logic [CH_W-1:0]    o_quot
);

    logic [ACC_W-1:0] r_quo;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] r_div;
    logic [4:0]       r_steps;
    logic             r_ovf;
    logic             r_busy;

    logic [ACC_W:0]   w_biased;
    logic [CNT_W:0]   w_shift;
    logic             w_fits;
    logic [CNT_W-1:0] w_remNext;
    logic [ACC_W-1:0] w_quoNext;

`ifdef KMEANS_ROUND_EN
    assign w_biased = {1'b0, i_dividend} + {{(ACC_W-CNT_W+1){1'b0}}, (i_divisor >> 1)};
`else
    assign w_biased = {1'b0, i_dividend};
`endif

    // The remainder after a successful subtract is below the divisor, so 12-bit wrap is exact.
    assign w_shift   = {r_rem, r_quo[ACC_W-1]};
    assign w_fits    = (w_shift >= {1'b0, r_div});
    assign w_remNext = w_fits ? (w_shift[CNT_W-1:0] - r_div) : w_shift[CNT_W-1:0];
    assign w_quoNext = {r_quo[ACC_W-2:0], w_fits};

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_steps == 5'd1);
    assign o_quot = (r_ovf || (|w_quoNext[ACC_W-1:CH_W])) ? {CH_W{1'b1}} : w_quoNext[CH_W-1:0];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_quo   <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_steps <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
        end else if (i_start) begin
            r_quo   <= w_biased[ACC_W-1:0];
            r_ovf   <= w_biased[ACC_W];
            r_rem   <= '0;
            r_div   <= i_divisor;
            r_steps <= 5'(DIV_STEPS);
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            r_quo   <= w_quoNext;
            r_rem   <= w_remNext;
            r_steps <= r_steps - 5'd1;
            if (r_steps == 5'd1) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/kmeans_iter_ctrl.sv
// K-means iteration controller: sequences passes, divides sums into new means, checks convergence.
// Build option KMEANS_ROUND_EN selects round-to-nearest means (see kmeans_seq_div).
module kmeans_iter_ctrl
    import kmeans_pkg::*;
#(
    parameter int K        = 4,
    parameter int NPIX     = 4096,
    parameter int MAX_ITER = 16,
    parameter int TOL      = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [K*PIX_W-1:0]   i_init_means,
    input  logic                 i_pix_valid,
    output logic                 o_pix_ready,
    output logic                 o_acc_clr,
    output logic                 o_pass_en,
    input  logic [K*3*ACC_W-1:0] i_acc_in,
    input  logic [K*CNT_W-1:0]   i_cnt_in,
    output logic [K*PIX_W-1:0]   o_means,
    output logic [4:0]           o_iter,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_converged
);

    localparam int PC_W = $clog2(NPIX + 1);
    localparam int CL_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [4:0] SLOT_LAST = 5'(DIV_STEPS);

    state_t             r_state;
    state_t             w_nextState;
    logic [PC_W-1:0]    r_pixCnt;
    logic [4:0]         r_slotCyc;
    logic [CL_W-1:0]    r_cluster;
    logic [1:0]         r_chan;
    logic [K*PIX_W-1:0] r_means;
    logic [K*PIX_W-1:0] r_shadow;
    logic [4:0]         r_iter;
    logic               r_converged;

    int                 w_byte;
    logic [ACC_W-1:0]   w_sum;
    logic [CNT_W-1:0]   w_cnt;
    logic               w_divStart;
    logic               w_divBusy;
    logic               w_divDone;
    logic [CH_W-1:0]    w_quot;
    logic               w_lastSlot;
    logic               w_convNow;
    logic [4:0]         w_iterInc;

    // Mean bytes are laid out B,G,R per cluster, so channel R of cluster c is byte 3c+2.
    assign w_byte     = int'(r_cluster) * 3 + 2 - int'(r_chan);
    assign w_sum      = i_acc_in[w_byte*ACC_W +: ACC_W];
    assign w_cnt      = i_cnt_in[int'(r_cluster)*CNT_W +: CNT_W];
    assign w_divStart = (r_state == S_DIV) && (r_slotCyc == 5'd0) && !w_divBusy;
    assign w_lastSlot = (r_cluster == CL_W'(K-1)) && (r_chan == 2'd2) && (r_slotCyc == SLOT_LAST);
    assign w_iterInc  = r_iter + 5'd1;

    kmeans_seq_div u_div (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (w_divStart),
        .i_dividend (w_sum),
        .i_divisor  (w_cnt),
        .o_busy     (w_divBusy),
        .o_done     (w_divDone),
        .o_quot     (w_quot)
    );

    always_comb begin
        w_convNow = 1'b1;
        for (int b = 0; b < 3*K; b++) begin
            if (absDiff(r_shadow[b*CH_W +: CH_W], r_means[b*CH_W +: CH_W]) > CH_W'(TOL)) begin
                w_convNow = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (i_start) w_nextState = S_CLEAR;
            S_CLEAR:        w_nextState = S_PASS;
            S_PASS:         if (i_pix_valid && (r_pixCnt == PC_W'(NPIX-1))) w_nextState = S_DRAIN;
            S_DRAIN:        w_nextState = S_DIV;
            S_DIV:          if (w_lastSlot) w_nextState = S_CHECK;
            S_CHECK:        w_nextState = (w_convNow || (w_iterInc == 5'(MAX_ITER))) ? S_DONE : S_CLEAR;
            default:        w_nextState = S_IDLE;
        endcase
    end

    // Every division slot is the same length; empty clusters just keep their old byte.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pixCnt    <= '0;
            r_slotCyc   <= '0;
            r_cluster   <= '0;
            r_chan      <= '0;
            r_means     <= '0;
            r_shadow    <= '0;
            r_iter      <= '0;
            r_converged <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_means     <= i_init_means;
                        r_iter      <= '0;
                        r_converged <= 1'b0;
                    end
                end
                S_CLEAR: r_pixCnt <= '0;
                S_PASS:  if (i_pix_valid) r_pixCnt <= r_pixCnt + 1'b1;
                S_DRAIN: begin
                    r_slotCyc <= '0;
                    r_cluster <= '0;
                    r_chan    <= '0;
                end
                S_DIV: begin
                    if (r_slotCyc == SLOT_LAST) begin
                        r_slotCyc <= '0;
                        if (w_divDone && (w_cnt != '0)) begin
                            r_shadow[w_byte*CH_W +: CH_W] <= w_quot;
                        end else begin
                            r_shadow[w_byte*CH_W +: CH_W] <= r_means[w_byte*CH_W +: CH_W];
                        end
                        if (r_chan == 2'd2) begin
                            r_chan    <= '0;
                            r_cluster <= r_cluster + 1'b1;
                        end else begin
                            r_chan <= r_chan + 2'd1;
                        end
                    end else begin
                        r_slotCyc <= r_slotCyc + 5'd1;
                    end
                end
                S_CHECK: begin
                    r_means <= r_shadow;
                    r_iter  <= w_iterInc;
                    if (w_nextState == S_DONE) begin
                        r_converged <= w_convNow;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_pix_ready = (r_state == S_PASS);
    assign o_acc_clr   = (r_state == S_CLEAR);
    assign o_pass_en   = i_pix_valid && (r_state == S_PASS);
    assign o_means     = r_means;
    assign o_iter      = r_iter;
    assign o_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done      = (r_state == S_DONE);
    assign o_converged = r_converged;

endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// Directed bench for kmeans_iter_ctrl with K=2, NPIX=4, MAX_ITER=3 at three tolerances.
// Expected rounded means follow KMEANS_ROUND_EN when it is defined.
module tb_kmeans_iter_ctrl;

    localparam int K        = 2;
    localparam int NPIX     = 4;
    localparam int MAX_ITER = 3;
    localparam int MW       = K*24;
    localparam int AW       = K*72;
    localparam int CW       = K*12;
    localparam int NVEC     = 5;

`ifdef KMEANS_ROUND_EN
    localparam logic [23:0] V1_C0 = 24'h032030;
    localparam logic [23:0] V4_C0 = 24'h21AA03;
`else
    localparam logic [23:0] V1_C0 = 24'h022030;
    localparam logic [23:0] V4_C0 = 24'h21AA02;
`endif

    typedef struct {
        logic [MW-1:0] init;
        logic [AW-1:0] acc;
        logic [CW-1:0] cnt;
        logic          toggle;
        logic [MW-1:0] expMeans;
        logic [4:0]    expIter;
        logic          expConv;
    } vec_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic [MW-1:0] initMeans;
    logic          pixValid;
    logic [AW-1:0] accIn;
    logic [CW-1:0] cntIn;

    logic          pixReadyA, accClrA, passEnA, busyA, doneA, convA;
    logic [MW-1:0] meansA;
    logic [4:0]    iterA;
    logic          pixReadyB, accClrB, passEnB, busyB, doneB, convB;
    logic [MW-1:0] meansB;
    logic [4:0]    iterB;
    logic          pixReadyC, accClrC, passEnC, busyC, doneC, convC;
    logic [MW-1:0] meansC;
    logic [4:0]    iterC;

    logic [AW-1:0] accSet0, accSet1;
    logic [CW-1:0] cntSet0;
    logic          toggleMode, oscillate;
    int            passCycles, acceptCnt, badEnCnt;
    int            checks, errors;
    vec_t          vecs[NVEC];

    kmeans_iter_ctrl #(.K(K), .NPIX(NPIX), .MAX_ITER(MAX_ITER), .TOL(0)) dutA (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_init_means(initMeans),
        .i_pix_valid(pixValid), .o_pix_ready(pixReadyA), .o_acc_clr(accClrA), .o_pass_en(passEnA),
        .i_acc_in(accIn), .i_cnt_in(cntIn), .o_means(meansA), .o_iter(iterA),
        .o_busy(busyA), .o_done(doneA), .o_converged(convA)
    );

    kmeans_iter_ctrl #(.K(K), .NPIX(NPIX), .MAX_ITER(MAX_ITER), .TOL(2)) dutB (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_init_means(initMeans),
        .i_pix_valid(pixValid), .o_pix_ready(pixReadyB), .o_acc_clr(accClrB), .o_pass_en(passEnB),
        .i_acc_in(accIn), .i_cnt_in(cntIn), .o_means(meansB), .o_iter(iterB),
        .o_busy(busyB), .o_done(doneB), .o_converged(convB)
    );

    kmeans_iter_ctrl #(.K(K), .NPIX(NPIX), .MAX_ITER(MAX_ITER), .TOL(1)) dutC (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_init_means(initMeans),
        .i_pix_valid(pixValid), .o_pix_ready(pixReadyC), .o_acc_clr(accClrC), .o_pass_en(passEnC),
        .i_acc_in(accIn), .i_cnt_in(cntIn), .o_means(meansC), .o_iter(iterC),
        .o_busy(busyC), .o_done(doneC), .o_converged(convC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW-1:0] packAcc(input logic [23:0] r0, input logic [23:0] g0, input logic [23:0] b0,
                                              input logic [23:0] r1, input logic [23:0] g1, input logic [23:0] b1);
        return {r1, g1, b1, r0, g0, b0};
    endfunction

    // Pixel source: every PASS cycle valid, or alternating starting low in toggle mode.
    initial begin
        int passIdx;
        passIdx  = 0;
        pixValid = 1'b0;
        forever begin
            @(negedge clk);
            if (pixReadyA) begin
                pixValid = toggleMode ? passIdx[0] : 1'b1;
                passIdx++;
            end else begin
                pixValid = 1'b0;
                passIdx  = 0;
            end
        end
    end

    // Thread model: accumulators are presented after each clear, alternating sets when oscillating.
    initial begin
        accIn = '0;
        cntIn = '0;
        forever begin
            @(posedge accClrA);
            #1;
            accIn = (oscillate && iterA[0]) ? accSet1 : accSet0;
            cntIn = cntSet0;
        end
    end

    initial begin
        passCycles = 0;
        acceptCnt  = 0;
        badEnCnt   = 0;
        forever begin
            @(negedge clk);
            #2;
            if (pixReadyA) passCycles++;
            if (passEnA) acceptCnt++;
            if (passEnA && !pixValid) badEnCnt++;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting, expected event", name);
    endtask

    task automatic applyStimulus(input logic [MW-1:0] init, input logic [AW-1:0] acc, input logic [AW-1:0] accAlt,
                                 input logic [CW-1:0] cnt, input logic tog, input logic osc);
        initMeans  = init;
        accSet0    = acc;
        accSet1    = accAlt;
        cntSet0    = cnt;
        toggleMode = tog;
        oscillate  = osc;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!busyA && !busyB && !busyC) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeoutFail(name);
    endtask

    task automatic waitReady(input logic level, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (pixReadyA == level) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeoutFail(name);
    endtask

    initial begin
        int pc0, ac0, bad0, n;
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        start      = 1'b0;
        initMeans  = '0;
        accSet0    = '0;
        accSet1    = '0;
        cntSet0    = '0;
        toggleMode = 1'b0;
        oscillate  = 1'b0;

        vecs[0] = '{init: {24'hFFFFFF, 24'h000000}, acc: packAcc(24'h40, 24'h80, 24'hC0, 24'h0, 24'h0, 24'h0),
                    cnt: {12'd0, 12'd4}, toggle: 1'b0, expMeans: {24'hFFFFFF, 24'h102030}, expIter: 5'd2, expConv: 1'b1};
        vecs[1] = '{init: {24'hFFFFFF, 24'h000000}, acc: packAcc(24'd10, 24'h80, 24'hC0, 24'h0, 24'h0, 24'h0),
                    cnt: {12'd0, 12'd4}, toggle: 1'b1, expMeans: {24'hFFFFFF, V1_C0}, expIter: 5'd2, expConv: 1'b1};
        vecs[2] = '{init: {24'hFFFFFF, 24'h000000}, acc: packAcc(24'hFFFFFF, 24'h3FC, 24'h400, 24'h55, 24'hAA, 24'h01),
                    cnt: {12'd1, 12'd4}, toggle: 1'b0, expMeans: {24'h55AA01, 24'hFFFFFF}, expIter: 5'd2, expConv: 1'b1};
        vecs[3] = '{init: {24'hFFFFFF, 24'h102030}, acc: packAcc(24'h40, 24'h80, 24'hC0, 24'h0, 24'h0, 24'h0),
                    cnt: {12'd0, 12'd4}, toggle: 1'b0, expMeans: {24'hFFFFFF, 24'h102030}, expIter: 5'd1, expConv: 1'b1};
        vecs[4] = '{init: {24'h000000, 24'h000000}, acc: packAcc(24'd100, 24'h1FF, 24'd8, 24'h700, 24'd50, 24'd0),
                    cnt: {12'd7, 12'd3}, toggle: 1'b1, expMeans: {24'hFF0700, V4_C0}, expIter: 5'd2, expConv: 1'b1};

        repeat (3) @(negedge clk);
        checkOutput("reset busy", 64'(busyA), 64'(0));
        checkOutput("reset done", 64'(doneA), 64'(0));
        checkOutput("reset means", 64'(meansA), 64'(0));
        checkOutput("reset iter", 64'(iterA), 64'(0));
        checkOutput("reset pix_ready", 64'(pixReadyA), 64'(0));
        checkOutput("reset acc_clr", 64'(accClrA), 64'(0));
        checkOutput("reset converged", 64'(convA), 64'(0));
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            pc0  = passCycles;
            ac0  = acceptCnt;
            bad0 = badEnCnt;
            applyStimulus(vecs[i].init, vecs[i].acc, vecs[i].acc, vecs[i].cnt, vecs[i].toggle, 1'b0);
            if (i == 0) begin
                checkOutput("start->acc_clr", 64'(accClrA), 64'(1));
                checkOutput("start->no pix_ready yet", 64'(pixReadyA), 64'(0));
                @(negedge clk);
                checkOutput("clear->pix_ready", 64'(pixReadyA), 64'(1));
                checkOutput("acc_clr one cycle", 64'(accClrA), 64'(0));
            end
            waitIdle($sformatf("vec%0d completion", i));
            checkOutput($sformatf("vec%0d means", i), 64'(meansA), 64'(vecs[i].expMeans));
            checkOutput($sformatf("vec%0d iter", i), 64'(iterA), 64'(vecs[i].expIter));
            checkOutput($sformatf("vec%0d converged", i), 64'(convA), 64'(vecs[i].expConv));
            checkOutput($sformatf("vec%0d done", i), 64'(doneA), 64'(1));
            checkOutput($sformatf("vec%0d pass cycles", i), 64'(passCycles - pc0),
                        64'(int'(vecs[i].expIter) * (vecs[i].toggle ? 8 : 4)));
            checkOutput($sformatf("vec%0d accepted", i), 64'(acceptCnt - ac0), 64'(int'(vecs[i].expIter) * 4));
            checkOutput($sformatf("vec%0d pass_en w/o valid", i), 64'(badEnCnt - bad0), 64'(0));
        end

        // Means swing 101010 <-> 808080 every iteration, so only the cap can stop the run.
        applyStimulus({24'hFFFFFF, 24'h000000},
                      packAcc(24'h40, 24'h40, 24'h40, 24'h0, 24'h0, 24'h0),
                      packAcc(24'h200, 24'h200, 24'h200, 24'h0, 24'h0, 24'h0),
                      {12'd0, 12'd4}, 1'b0, 1'b1);
        waitIdle("oscillate completion");
        checkOutput("osc A iter", 64'(iterA), 64'(3));
        checkOutput("osc A converged", 64'(convA), 64'(0));
        checkOutput("osc A means", 64'(meansA), 64'({24'hFFFFFF, 24'h101010}));
        checkOutput("osc B iter", 64'(iterB), 64'(3));
        checkOutput("osc B converged", 64'(convB), 64'(0));
        checkOutput("osc C iter", 64'(iterC), 64'(3));
        checkOutput("osc C converged", 64'(convC), 64'(0));

        // First iteration moves R of cluster 0 by exactly 2; cluster 1 is empty.
        applyStimulus({24'h405060, 24'h102030},
                      packAcc(24'h48, 24'h80, 24'hC0, 24'h0, 24'h0, 24'h0),
                      packAcc(24'h48, 24'h80, 24'hC0, 24'h0, 24'h0, 24'h0),
                      {12'd0, 12'd4}, 1'b0, 1'b0);
        waitIdle("tolerance completion");
        checkOutput("tol0 iter", 64'(iterA), 64'(2));
        checkOutput("tol0 converged", 64'(convA), 64'(1));
        checkOutput("tol2 iter", 64'(iterB), 64'(1));
        checkOutput("tol2 converged", 64'(convB), 64'(1));
        checkOutput("tol2 means", 64'(meansB), 64'({24'h405060, 24'h122030}));
        checkOutput("tol1 iter", 64'(iterC), 64'(2));
        checkOutput("tol1 converged", 64'(convC), 64'(1));
        checkOutput("tol1 means", 64'(meansC), 64'({24'h405060, 24'h122030}));

        applyStimulus(vecs[0].init, vecs[0].acc, vecs[0].acc, vecs[0].cnt, 1'b0, 1'b0);
        waitReady(1'b1, "pass entry before reset");
        waitReady(1'b0, "drain before reset");
        repeat (20) @(negedge clk);
        checkOutput("busy during div", 64'(busyA), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        checkOutput("div reset busy", 64'(busyA), 64'(0));
        checkOutput("div reset means", 64'(meansA), 64'(0));
        checkOutput("div reset iter", 64'(iterA), 64'(0));
        checkOutput("div reset done", 64'(doneA), 64'(0));
        checkOutput("div reset converged", 64'(convA), 64'(0));
        checkOutput("div reset pix_ready", 64'(pixReadyA), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // From the drain cycle: 150 division cycles, one check cycle, then the update shows.
        applyStimulus(vecs[0].init, vecs[0].acc, vecs[0].acc, vecs[0].cnt, 1'b0, 1'b0);
        waitReady(1'b1, "pass entry after reset");
        waitReady(1'b0, "drain after reset");
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n++;
            if (iterA != 5'd0) break;
        end
        checkOutput("drain to update cycles", 64'(n), 64'(152));
        checkOutput("iter1 means", 64'(meansA), 64'({24'hFFFFFF, 24'h102030}));
        checkOutput("iter1 still busy", 64'(busyA), 64'(1));
        waitIdle("restart completion");
        checkOutput("restart means", 64'(meansA), 64'({24'hFFFFFF, 24'h102030}));
        checkOutput("restart iter", 64'(iterA), 64'(2));
        checkOutput("restart converged", 64'(convA), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
